// File: rtl/game_io_ctrl.sv
// Port-mapped I/O controller for a KCPSM6 game core: write-decoded output registers,
// a registered input mux and a three-source interrupt block with mask and W1C pending bits.
module game_io_ctrl #(
    parameter int NUM_DIGITS     = 4,
    parameter int PERIOD_W       = 24,
    parameter int DEFAULT_PERIOD = 10_000_000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3:0]              db_btns,
    input  logic [7:0]              db_sw,
    input  logic [1:0]              randomized_value,
    input  logic                    collison_detect,
    input  logic [7:0]              port_id,
    input  logic [7:0]              out_port,
    input  logic                    write_strobe,
    input  logic                    k_write_strobe,
    input  logic                    read_strobe,
    input  logic                    interrupt_ack,
    output logic [7:0]              in_port,
    output logic                    interrupt,
    output logic [7:0]              led,
    output logic [5*NUM_DIGITS-1:0] dig,
    output logic [NUM_DIGITS-1:0]   dp,
    output logic [7:0]              game_info
);

    // Staging holds three bytes; bits at or above PERIOD_W are never stored.
    localparam logic [23:0] STAGE_MASK = 24'((64'd1 << PERIOD_W) - 64'd1);

    logic [7:0]              led_r;
    logic [5*NUM_DIGITS-1:0] dig_r;
    logic [NUM_DIGITS-1:0]   dp_r;
    logic [7:0]              game_info_r;
    logic [7:0]              in_port_r;
    logic                    irq_r;
    logic [23:0]             stage_r;
    logic [PERIOD_W-1:0]     period_r;
    logic [PERIOD_W-1:0]     count_r;
    logic [3:0]              irq_mask_r;
    logic [3:0]              irq_pending_r;
    logic                    coll_prev_r;
    logic [3:0]              btn_prev_r;

    logic                    wr_led_s;
    logic                    wr_dp_s;
    logic                    wr_info_s;
    logic                    wr_lo_s;
    logic                    wr_mid_s;
    logic                    commit_s;
    logic                    wr_mask_s;
    logic                    wr_clr_s;
    logic [NUM_DIGITS-1:0]   dig_we_s;
    logic [23:0]             commit_val_s;
    logic                    tick_s;
    logic                    coll_rise_s;
    logic                    btn_rise_s;
    logic [3:0]              set_s;
    logic [3:0]              clr_s;
    logic [3:0]              pending_next_s;
    logic [7:0]              rd_data_s;
    logic                    unused_s;

    function automatic logic rise_f(input logic live, input logic prev);
        return live & ~prev;
    endfunction

    assign unused_s = &{1'b0, k_write_strobe, read_strobe};

    // Write address decode; only write_strobe qualifies a port write.
    always_comb begin
        wr_led_s  = write_strobe && (port_id == 8'h02);
        wr_dp_s   = write_strobe && (port_id == 8'h07);
        wr_info_s = write_strobe && (port_id == 8'h09);
        wr_lo_s   = write_strobe && (port_id == 8'h0A);
        wr_mid_s  = write_strobe && (port_id == 8'h0B);
        commit_s  = write_strobe && (port_id == 8'h0C);
        wr_mask_s = write_strobe && (port_id == 8'h0D);
        wr_clr_s  = write_strobe && (port_id == 8'h0E);
        dig_we_s  = {NUM_DIGITS{1'b0}};
        for (int k = 0; k < NUM_DIGITS; k++) begin
            // Lowest digit address maps to the most significant digit.
            if (write_strobe && (port_id == 8'(3 + NUM_DIGITS - 1 - k))) begin
                dig_we_s[k] = 1'b1;
            end else begin
                dig_we_s[k] = 1'b0;
            end
        end
    end

    // Timer, edge detection and pending-bit next-state logic.
    always_comb begin
        commit_val_s   = {out_port, stage_r[15:0]} & STAGE_MASK;
        tick_s         = (period_r != {PERIOD_W{1'b0}}) &&
                         (count_r == (period_r - PERIOD_W'(1)));
        coll_rise_s    = rise_f(collison_detect, coll_prev_r);
        btn_rise_s     = |(db_btns & ~btn_prev_r);
        set_s          = {tick_s & irq_pending_r[0], btn_rise_s, coll_rise_s, tick_s};
        if (wr_clr_s) begin
            clr_s = out_port[3:0];
        end else begin
            clr_s = 4'b0000;
        end
        pending_next_s = (irq_pending_r & ~clr_s) | set_s;
    end

    // Read mux; unmapped addresses return zero.
    always_comb begin
        case (port_id)
            8'h00:   rd_data_s = {4'b0000, db_btns};
            8'h01:   rd_data_s = db_sw;
            8'h02:   rd_data_s = {7'b0000000, collison_detect};
            8'h0D:   rd_data_s = {4'b0000, irq_mask_r};
            8'h0E:   rd_data_s = {4'b0000, irq_pending_r};
            8'h0F:   rd_data_s = {6'b000000, randomized_value};
            default: rd_data_s = 8'h00;
        endcase
    end

    // Software-visible output registers and period staging.
    always_ff @(posedge clk) begin
        if (!rst) begin
            led_r       <= 8'h00;
            dig_r       <= {(5*NUM_DIGITS){1'b0}};
            dp_r        <= {NUM_DIGITS{1'b0}};
            game_info_r <= 8'h00;
            stage_r     <= 24'h000000;
            period_r    <= PERIOD_W'(DEFAULT_PERIOD);
            irq_mask_r  <= 4'b0001;
        end else begin
            if (wr_led_s)  led_r       <= out_port;
            if (wr_dp_s)   dp_r        <= out_port[NUM_DIGITS-1:0];
            if (wr_info_s) game_info_r <= out_port;
            if (wr_mask_s) irq_mask_r  <= out_port[3:0];
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (dig_we_s[k]) dig_r[5*k +: 5] <= out_port[4:0];
            end
            if (wr_lo_s)  stage_r[7:0]   <= out_port & STAGE_MASK[7:0];
            if (wr_mid_s) stage_r[15:8]  <= out_port & STAGE_MASK[15:8];
            if (commit_s) begin
                stage_r[23:16] <= out_port & STAGE_MASK[23:16];
                period_r       <= PERIOD_W'(commit_val_s);
            end
        end
    end

    // Tick counter: wraps on tick, restarts on commit, parks at zero when disabled.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_r <= {PERIOD_W{1'b0}};
        end else if (commit_s || tick_s || (period_r == {PERIOD_W{1'b0}})) begin
            count_r <= {PERIOD_W{1'b0}};
        end else begin
            count_r <= count_r + PERIOD_W'(1);
        end
    end

    // Edge-detect history tracks the inputs even in reset, so levels held across release do not fire.
    always_ff @(posedge clk) begin
        coll_prev_r <= collison_detect;
        btn_prev_r  <= db_btns;
    end

    // Pending bits, interrupt request and registered read data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            irq_pending_r <= 4'b0000;
            irq_r         <= 1'b0;
            in_port_r     <= 8'h00;
        end else begin
            irq_pending_r <= pending_next_s;
            if (interrupt_ack) begin
                irq_r <= 1'b0;
            end else begin
                irq_r <= |(irq_pending_r & irq_mask_r);
            end
            in_port_r <= rd_data_s;
        end
    end

    assign led       = led_r;
    assign dig       = dig_r;
    assign dp        = dp_r;
    assign game_info = game_info_r;
    assign in_port   = in_port_r;
    assign interrupt = irq_r;

endmodule

// File: tb/tb_game_io_ctrl.sv
// Directed bench for game_io_ctrl with two digits; inputs change and outputs are sampled on falling edges.
module tb_game_io_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] db_btns;
    logic [7:0] db_sw;
    logic [1:0] randomized_value;
    logic       collison_detect;
    logic [7:0] port_id;
    logic [7:0] out_port;
    logic       write_strobe;
    logic       k_write_strobe;
    logic       read_strobe;
    logic       interrupt_ack;
    logic [7:0] in_port;
    logic       interrupt;
    logic [7:0] led;
    logic [9:0] dig;
    logic [1:0] dp;
    logic [7:0] game_info;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total_cnt = 0;
    int rises;
    logic prev_int;

    always #5 clk = ~clk;

    game_io_ctrl #(
        .NUM_DIGITS(2),
        .PERIOD_W(24),
        .DEFAULT_PERIOD(10_000_000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .db_btns(db_btns),
        .db_sw(db_sw),
        .randomized_value(randomized_value),
        .collison_detect(collison_detect),
        .port_id(port_id),
        .out_port(out_port),
        .write_strobe(write_strobe),
        .k_write_strobe(k_write_strobe),
        .read_strobe(read_strobe),
        .interrupt_ack(interrupt_ack),
        .in_port(in_port),
        .interrupt(interrupt),
        .led(led),
        .dig(dig),
        .dp(dp),
        .game_info(game_info)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        port_id      = a;
        out_port     = d;
        write_strobe = 1'b1;
        @(negedge clk);
        write_strobe = 1'b0;
    endtask

    initial begin
        rst = 1'b0; db_btns = 4'h0; db_sw = 8'h00; randomized_value = 2'b00;
        collison_detect = 1'b0; port_id = 8'h0D; out_port = 8'h00;
        write_strobe = 1'b0; k_write_strobe = 1'b0; read_strobe = 1'b0; interrupt_ack = 1'b0;

        // Reset defaults
        cyc(3);
        check("rst_led", 32'(led), 32'h00);
        check("rst_dig", 32'(dig), 32'h000);
        check("rst_dp", 32'(dp), 32'h0);
        check("rst_info", 32'(game_info), 32'h00);
        check("rst_in_port", 32'(in_port), 32'h00);
        check("rst_irq", 32'(interrupt), 32'h0);
        rst = 1'b1;
        cyc(1);
        check("rst_mask_rd", 32'(in_port), 32'h01);
        port_id = 8'h0E;
        cyc(1);
        check("rst_pend_rd", 32'(in_port), 32'h00);

        // Period 5: tick sets pending at the 5th edge after commit, interrupt one edge later
        wr(8'h0A, 8'h05);
        wr(8'h0B, 8'h00);
        wr(8'h0C, 8'h00);
        cyc(5);
        check("irq_before_tick", 32'(interrupt), 32'h0);
        cyc(1);
        check("irq_after_tick", 32'(interrupt), 32'h1);
        interrupt_ack = 1'b1;
        cyc(1);
        check("irq_acked", 32'(interrupt), 32'h0);
        interrupt_ack = 1'b0;
        cyc(1);
        check("irq_reassert", 32'(interrupt), 32'h1);
        wr(8'h0E, 8'h01);
        check("irq_w1c_edge", 32'(interrupt), 32'h1);
        cyc(1);
        check("irq_after_w1c", 32'(interrupt), 32'h0);

        // Overrun: ticks at edges 10 and 15 with no clear in between
        cyc(5);
        port_id = 8'h0E;
        cyc(1);
        check("overrun_pend", 32'(in_port), 32'h09);
        wr(8'h0E, 8'h09);
        cyc(1);
        check("overrun_cleared", 32'(in_port), 32'h00);

        // Disable timer, clear everything, mask collision only
        wr(8'h0A, 8'h00);
        wr(8'h0B, 8'h00);
        wr(8'h0C, 8'h00);
        wr(8'h0E, 8'h0F);
        wr(8'h0D, 8'h02);
        port_id = 8'h0D;
        cyc(1);
        check("mask_rd", 32'(in_port), 32'h02);
        check("irq_idle", 32'(interrupt), 32'h0);

        // Collision held high: one rising edge only
        collison_detect = 1'b1;
        port_id = 8'h0E;
        prev_int = interrupt;
        rises = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            if (interrupt && !prev_int) rises++;
            prev_int = interrupt;
        end
        check("coll_irq_rises", 32'(rises), 32'd1);
        check("coll_pend", 32'(in_port), 32'h02);
        wr(8'h0E, 8'h02);
        port_id = 8'h0E;
        cyc(3);
        check("coll_no_retrig", 32'(in_port), 32'h00);
        check("coll_irq_low", 32'(interrupt), 32'h0);
        collison_detect = 1'b0;

        // Button edge with timer disabled
        wr(8'h0D, 8'h04);
        db_btns = 4'b0100;
        port_id = 8'h0E;
        cyc(10);
        check("btn_irq", 32'(interrupt), 32'h1);
        check("btn_pend", 32'(in_port), 32'h04);
        port_id = 8'h00;
        cyc(1);
        check("btn_rd", 32'(in_port), 32'h04);

        // Remaining read map
        db_sw = 8'h5A;
        port_id = 8'h01;
        cyc(1);
        check("sw_rd", 32'(in_port), 32'h5A);
        randomized_value = 2'b10;
        port_id = 8'h0F;
        cyc(1);
        check("rand_rd", 32'(in_port), 32'h02);
        collison_detect = 1'b1;
        port_id = 8'h02;
        cyc(1);
        check("coll_rd", 32'(in_port), 32'h01);
        collison_detect = 1'b0;

        // Write decode with two digits
        wr(8'h02, 8'hA5);
        wr(8'h07, 8'hFF);
        wr(8'h09, 8'h3C);
        check("led_wr", 32'(led), 32'hA5);
        check("dp_wr", 32'(dp), 32'h3);
        check("info_wr", 32'(game_info), 32'h3C);
        port_id = 8'h02;
        out_port = 8'h00;
        k_write_strobe = 1'b1;
        cyc(1);
        k_write_strobe = 1'b0;
        check("k_strobe_ignored", 32'(led), 32'hA5);
        wr(8'h03, 8'h1F);
        wr(8'h04, 8'h0A);
        wr(8'h05, 8'h33);
        wr(8'h20, 8'hFF);
        check("dig_decode", 32'(dig), 32'h3EA);
        check("led_kept", 32'(led), 32'hA5);
        check("dp_kept", 32'(dp), 32'h3);
        check("info_kept", 32'(game_info), 32'h3C);
        port_id = 8'h20;
        cyc(1);
        check("unmapped_rd", 32'(in_port), 32'h00);

        // Reset mid-run restores defaults
        rst = 1'b0;
        cyc(1);
        rst = 1'b1;
        check("rerst_led", 32'(led), 32'h00);
        check("rerst_dig", 32'(dig), 32'h000);
        port_id = 8'h0D;
        cyc(1);
        check("rerst_mask", 32'(in_port), 32'h01);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
